seq_detector_prog: RTL and testbench

- Runtime-programmable serial sequence detector, the parametrised successor of the team's fixed 4-state Mealy detector.
- Consumes one bit per accepted cycle and pulses `match` when the last `len` bits equal a loaded pattern of 1..PAT_W bits.
- Selectable overlapping or non-overlapping detection, plus a saturating hit counter.
- Sits on serial front-ends (framing/sync-word search) ahead of deserialisers.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/sat_counter.sv | 32 +++
 rtl/seq_detector_prog.sv | 143 ++++++++++++++
 tb/tb_seq_detector_prog.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HUNT = 2'd2
  } state_t;

  // A length of 0 or beyond the pattern register means "use the full register".
  function automatic int clamp_len(input int len, input int pat_w);
    return ((len == 0) || (len > pat_w)) ? pat_w : len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control and hit counter.
// Define SEQ_DET_MASK_EN to add a per-bit don't-care mask (cfg_mask).
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int  PAT_W = 8,
  parameter int  CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic             match_q, match_d;
`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_q, mask_d;
`endif

  logic             accept;
  logic             hit;
  logic [PAT_W-1:0] new_hist;
  logic [LEN_W-1:0] new_fill;
  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] diff;

  // Candidate history/fill for this cycle and the compare over the low len bits.
  always_comb begin
    accept   = en && in_valid && !cfg_load && (state_q != ST_IDLE);
    new_hist = {hist_q[PAT_W-2:0], in_bit};
    new_fill = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    len_mask = ~({PAT_W{1'b1}} << len_q);
`ifdef SEQ_DET_MASK_EN
    diff     = (new_hist ^ pattern_q) & len_mask & ~mask_q;
`else
    diff     = (new_hist ^ pattern_q) & len_mask;
`endif
    hit      = accept && (new_fill == len_q) && (diff == '0);
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    match_d   = hit;
`ifdef SEQ_DET_MASK_EN
    mask_d    = mask_q;
`endif
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
      overlap_d = cfg_overlap;
`ifdef SEQ_DET_MASK_EN
      mask_d    = cfg_mask;
`endif
      hist_d    = '0;
      fill_d    = '0;
      state_d   = en ? ST_FILL : ST_IDLE;
    end else if (!en) begin
      fill_d  = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL, ST_HUNT: begin
          if (accept) begin
            hist_d  = new_hist;
            fill_d  = new_fill;
            state_d = (new_fill == len_q) ? ST_HUNT : ST_FILL;
            // Non-overlapping: a hit consumes its bits, so search restarts empty.
            if (hit && !overlap_q) begin
              hist_d  = '0;
              fill_d  = '0;
              state_d = ST_FILL;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= '0;
      len_q     <= LEN_W'(PAT_W);
      overlap_q <= 1'b1;
      match_q   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (cfg_load),
    .q   (match_cnt)
  );

  assign match = match_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: a 16-bit-counter instance plus a 2-bit one for saturation.
module tb_seq_detector_prog;

  localparam int PAT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [PAT_W-1:0] cfg_mask;
  logic             match, match_s;
  logic [15:0]      match_cnt;
  logic [1:0]       cnt_s;
  logic [1:0]       state, state_s;

  logic exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .match(match), .match_cnt(match_cnt), .state(state)
  );

  seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .match(match_s), .match_cnt(cnt_s), .state(state_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_and_score(input string tag);
    @(posedge clk);
    #1;
    chk(tag, match, exp_q.pop_front());
  endtask

  task automatic send(input logic b, input logic exp_m);
    in_valid = 1'b1;
    in_bit   = b;
    exp_q.push_back(exp_m);
    tick_and_score("match");
    in_valid = 1'b0;
  endtask

  task automatic idle_cyc();
    in_valid = 1'b0;
    exp_q.push_back(1'b0);
    tick_and_score("gap_match");
  endtask

  // Bits are sent MSB first (bits[n-1] is the first bit on the wire).
  task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], exp[i]);
      repeat (gap) idle_cyc();
    end
  endtask

  // The bit offered alongside cfg_load must be discarded.
  task automatic load(input logic [7:0] pat, input logic [LEN_W-1:0] len, input logic ovl);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    exp_q.push_back(1'b0);
    tick_and_score("load_match");
    cfg_load = 1'b0;
    in_valid = 1'b0;
    chk("load_cnt", match_cnt, 32'd0);
    chk("load_state", state, 32'd1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b1; cfg_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", match, 32'd0);
    chk("rst_cnt", match_cnt, 32'd0);
    chk("rst_state", state, 32'd0);

    rst = 1'b1;
    en  = 1'b1;
    idle_cyc();
    chk("idle_to_fill", state, 32'd1);

    // Overlapping: upper pattern bits must be ignored with len=4.
    load(8'b1111_1011, 4'd4, 1'b1);
    stream(16'b1011011, 16'b0001001, 7, 0);
    chk("ovl_cnt", match_cnt, 32'd2);
    chk("ovl_state", state, 32'd2);

    // Non-overlapping: hit empties the history.
    load(8'b0000_1011, 4'd4, 1'b0);
    stream(16'b1011, 16'b0001, 4, 0);
    chk("novl_state_after_hit", state, 32'd1);
    stream(16'b011, 16'b000, 3, 0);
    chk("novl_cnt", match_cnt, 32'd1);

    // Two idle cycles between every valid bit.
    load(8'b0000_1011, 4'd4, 1'b1);
    stream(16'b1011011, 16'b0001001, 7, 2);
    chk("gap_cnt", match_cnt, 32'd2);

    // Reload mid-pattern discards pre-load history.
    load(8'b0000_1011, 4'd4, 1'b1);
    stream(16'b101, 16'b000, 3, 0);
    load(8'b0000_1011, 4'd4, 1'b1);
    send(1'b1, 1'b0);
    chk("midload_cnt0", match_cnt, 32'd0);
    stream(16'b011, 16'b001, 3, 0);
    chk("midload_cnt1", match_cnt, 32'd1);

    // Length clamping: 0 and 9 both mean the full 8 bits.
    load(8'hA5, 4'd0, 1'b1);
    stream(16'h00A5, 16'h0001, 8, 0);
    load(8'hA5, 4'd9, 1'b1);
    stream(16'h01A5, 16'h0001, 9, 0);
    chk("clamp_cnt", match_cnt, 32'd1);

    // len=1 with a 2-bit counter in the second instance.
    load(8'h01, 4'd1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 1'b1);
      chk("sat_match_s", match_s, 32'd1);
      chk("sat_cnt_s", cnt_s, (i > 3) ? 32'd3 : 32'(i));
      chk("sat_cnt", match_cnt, 32'(i));
    end
    chk("len1_state", state, 32'd2);
    send(1'b0, 1'b0);
    chk("sat_hold", cnt_s, 32'd3);

    // Reset lands on the edge that would complete a hit.
    load(8'b0000_1011, 4'd4, 1'b1);
    stream(16'b101, 16'b000, 3, 0);
    rst = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    exp_q.push_back(1'b0);
    tick_and_score("rst_hit_match");
    chk("rst_hit_cnt", match_cnt, 32'd0);
    chk("rst_hit_state", state, 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    idle_cyc();
    chk("post_rst_state", state, 32'd1);
    // Reset config is pattern=0, len=8, overlap on.
    stream(16'h0000, 16'h0001, 8, 0);
    stream(16'h0000, 16'h0001, 1, 0);
    chk("post_rst_cnt", match_cnt, 32'd2);

    // Dropping enable mid-pattern restarts the fill.
    load(8'b0000_1011, 4'd4, 1'b1);
    stream(16'b10, 16'b00, 2, 0);
    en = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    exp_q.push_back(1'b0);
    tick_and_score("en_off_match");
    chk("en_off_state", state, 32'd0);
    en = 1'b1;
    idle_cyc();
    chk("en_on_state", state, 32'd1);
    stream(16'b11011, 16'b00001, 5, 0);
    chk("en_cnt", match_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
